// File: rtl/mc_datapath_p.sv
// mc_datapath_p: multicycle RISC-V style datapath with an iterative multiplier.
//
// Ports
//   CLK          rising-edge clock
//   Reset        asynchronous active-low reset
//   ReadData     memory read data (instruction fetch and loads)
//   MemReady     memory ready; 0 freezes every register in the datapath
//   IRWrite      load Instr from ReadData and OldPC from PC
//   PCWrite      load PC from Result
//   RegWrite     write Result into register Instr[11:7]
//   ImmSrc       immediate format: 0 I, 1 S, 2 B, 3 U, 4 J
//   ByteSrc      load extension: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu
//   ALUSrcA      0 PC, 1 OldPC, 2 A
//   ALUSrcB      0 WriteData, 1 ImmExt, 2 constant 4
//   ALUControl   0 add 1 sub 2 and 3 or 4 xor 5 slt 6 sltu 7 sll 8 srl 9 sra
//   ResultSrc    0 ALUOut, 1 ByteExt, 2 ALUResult, 3 ImmExt, 4 MulOut
//   MulStart     start A x WriteData (low XLEN bits of the product)
//   MulBusy      multiplier iterating
//   MulDone      multiplier finished; high for one unstalled cycle
//   Zero         ALUResult == 0
//   Instr        instruction register
//   PC           program counter
//   Result       result bus
//   WriteData    latched second register operand
module mc_datapath_p #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic [XLEN-1:0] ReadData,
    input  logic            MemReady,
    input  logic            IRWrite,
    input  logic            PCWrite,
    input  logic            RegWrite,
    input  logic [2:0]      ImmSrc,
    input  logic [2:0]      ByteSrc,
    input  logic [1:0]      ALUSrcA,
    input  logic [1:0]      ALUSrcB,
    input  logic [3:0]      ALUControl,
    input  logic [2:0]      ResultSrc,
    input  logic            MulStart,
    output logic            MulBusy,
    output logic            MulDone,
    output logic            Zero,
    output logic [31:0]     Instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] Result,
    output logic [XLEN-1:0] WriteData
);

    localparam int SHW  = $clog2(XLEN);
    localparam int IDXW = $clog2(NREGS);
    localparam int CNTW = $clog2(XLEN);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(XLEN - 1);

    typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_t;

    // Architectural and intermediate state
    logic [XLEN-1:0] pc, old_pc, a_reg, wd_reg, alu_out, data_reg, mul_out;
    logic [31:0]     instr;
    logic [XLEN-1:0] rf [NREGS];

    // Multiplier state
    mul_state_t      mul_state, mul_next;
    logic [XLEN-1:0] mul_mcand, mul_mplier, mul_prod, mul_prod_next;
    logic [CNTW-1:0] mul_cnt;
    logic            mul_last;

    // Combinational datapath
    logic [4:0]             rs1, rs2, rd;
    logic [XLEN-1:0]        rd1, rd2, imm_ext, byte_ext, src_a, src_b, alu_result, result;
    logic signed [XLEN-1:0] src_a_s, src_b_s;
    logic [SHW-1:0]         shamt;

    // Opcode and funct3 are decoded by the external controller, not here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[14:12], instr[6:0]};

    function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] i, input logic [2:0] src);
        logic signed [31:0] v;
        case (src)
            3'd0:    v = {{20{i[31]}}, i[31:20]};
            3'd1:    v = {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    v = {i[31:12], 12'b0};
            3'd4:    v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: v = '0;
        endcase
        return sext32(v);
    endfunction

    function automatic logic [XLEN-1:0] load_ext(input logic [31:0] d, input logic [1:0] off,
                                                 input logic [2:0] src);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        case (src)
            3'd0:    return sext32({{24{b[7]}}, b});
            3'd1:    return sext32({{16{h[15]}}, h});
            3'd2:    return sext32(d);
            3'd4:    return XLEN'(b);
            3'd5:    return XLEN'(h);
            default: return '0;
        endcase
    endfunction

    // x0 and indices beyond the implemented register count read as zero
    // and are never written.
    function automatic logic reg_valid(input logic [4:0] idx);
        return (idx != 5'd0) && ({1'b0, idx} < 6'(NREGS));
    endfunction

    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];
    assign rd  = instr[11:7];

    assign rd1 = reg_valid(rs1) ? rf[rs1[IDXW-1:0]] : '0;
    assign rd2 = reg_valid(rs2) ? rf[rs2[IDXW-1:0]] : '0;

    assign imm_ext  = imm_gen(instr, ImmSrc);
    assign byte_ext = load_ext(data_reg[31:0], alu_out[1:0], ByteSrc);

    always_comb begin
        case (ALUSrcA)
            2'd0:    src_a = pc;
            2'd1:    src_a = old_pc;
            2'd2:    src_a = a_reg;
            default: src_a = '0;
        endcase
        case (ALUSrcB)
            2'd0:    src_b = wd_reg;
            2'd1:    src_b = imm_ext;
            2'd2:    src_b = XLEN'(4);
            default: src_b = '0;
        endcase
    end

    assign src_a_s = src_a;
    assign src_b_s = src_b;
    assign shamt   = src_b[SHW-1:0];

    always_comb begin
        alu_result = '0;
        case (ALUControl)
            4'd0: alu_result = src_a + src_b;
            4'd1: alu_result = src_a - src_b;
            4'd2: alu_result = src_a & src_b;
            4'd3: alu_result = src_a | src_b;
            4'd4: alu_result = src_a ^ src_b;
            4'd5: alu_result[0] = (src_a_s < src_b_s);
            4'd6: alu_result[0] = (src_a < src_b);
            4'd7: alu_result = src_a << shamt;
            4'd8: alu_result = src_a >> shamt;
            4'd9: alu_result = src_a_s >>> shamt;
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        case (ResultSrc)
            3'd0:    result = alu_out;
            3'd1:    result = byte_ext;
            3'd2:    result = alu_result;
            3'd3:    result = imm_ext;
            3'd4:    result = mul_out;
            default: result = '0;
        endcase
    end

    assign Zero      = (alu_result == '0);
    assign Instr     = instr;
    assign PC        = pc;
    assign Result    = result;
    assign WriteData = wd_reg;

    // Datapath registers and register file
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            pc       <= RESET_PC;
            instr    <= 32'h0000_0013;
            old_pc   <= '0;
            a_reg    <= '0;
            wd_reg   <= '0;
            alu_out  <= '0;
            data_reg <= '0;
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (MemReady) begin
            if (PCWrite) pc <= result;
            if (IRWrite) begin
                instr  <= ReadData[31:0];
                old_pc <= pc;
            end
            a_reg    <= rd1;
            wd_reg   <= rd2;
            alu_out  <= alu_result;
            data_reg <= ReadData;
            if (RegWrite && reg_valid(rd)) rf[rd[IDXW-1:0]] <= result;
        end
    end

    // Multiplier control
    assign mul_last = (mul_cnt == CNT_LAST);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset)        mul_state <= MUL_IDLE;
        else if (MemReady) mul_state <= mul_next;
    end

    always_comb begin
        mul_next = mul_state;
        case (mul_state)
            MUL_IDLE: if (MulStart) mul_next = MUL_RUN;
            MUL_RUN:  if (mul_last) mul_next = MUL_DONE;
            MUL_DONE: mul_next = MUL_IDLE;
            default:  mul_next = MUL_IDLE;
        endcase
    end

    assign MulBusy = (mul_state == MUL_RUN);
    assign MulDone = (mul_state == MUL_DONE);

    // Shift-add iteration: multiplicand moves left, multiplier moves right.
    assign mul_prod_next = mul_prod + (mul_mplier[0] ? mul_mcand : '0);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_prod   <= '0;
            mul_cnt    <= '0;
            mul_out    <= '0;
        end else if (MemReady) begin
            case (mul_state)
                MUL_IDLE: begin
                    if (MulStart) begin
                        mul_mcand  <= a_reg;
                        mul_mplier <= wd_reg;
                        mul_prod   <= '0;
                        mul_cnt    <= '0;
                    end
                end
                MUL_RUN: begin
                    mul_mcand  <= mul_mcand << 1;
                    mul_mplier <= mul_mplier >> 1;
                    mul_prod   <= mul_prod_next;
                    mul_cnt    <= mul_cnt + 1'b1;
                    if (mul_last) mul_out <= mul_prod_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_datapath_p.sv
module tb_mc_datapath_p;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] ReadData;
    logic        MemReady, IRWrite, PCWrite, RegWrite, MulStart;
    logic [2:0]  ImmSrc, ByteSrc, ResultSrc;
    logic [1:0]  ALUSrcA, ALUSrcB;
    logic [3:0]  ALUControl;

    logic        MulBusy, MulDone, Zero;
    logic [31:0] Instr, PC, Result, WriteData;
    logic        MulBusy16, MulDone16, Zero16;
    logic [31:0] Instr16, PC16, Result16, WriteData16;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 CLK = ~CLK;

    mc_datapath_p #(.XLEN(32), .NREGS(32), .RESET_PC(32'h100)) dut (
        .CLK(CLK), .Reset(Reset), .ReadData(ReadData), .MemReady(MemReady),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .ImmSrc(ImmSrc), .ByteSrc(ByteSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ResultSrc(ResultSrc), .MulStart(MulStart),
        .MulBusy(MulBusy), .MulDone(MulDone), .Zero(Zero), .Instr(Instr),
        .PC(PC), .Result(Result), .WriteData(WriteData)
    );

    mc_datapath_p #(.XLEN(32), .NREGS(16)) dut16 (
        .CLK(CLK), .Reset(Reset), .ReadData(ReadData), .MemReady(MemReady),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .ImmSrc(ImmSrc), .ByteSrc(ByteSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ResultSrc(ResultSrc), .MulStart(MulStart),
        .MulBusy(MulBusy16), .MulDone(MulDone16), .Zero(Zero16), .Instr(Instr16),
        .PC(PC16), .Result(Result16), .WriteData(WriteData16)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // fetch, decode, execute (addi), writeback
    task automatic exec_addi(input logic [31:0] ins);
        ReadData = ins; IRWrite = 1'b1; tick();
        IRWrite = 1'b0; tick();
        ImmSrc = 3'd0; ALUSrcA = 2'd2; ALUSrcB = 2'd1; ALUControl = 4'd0; ResultSrc = 3'd2;
        tick();
        ResultSrc = 3'd0; RegWrite = 1'b1; tick();
        RegWrite = 1'b0;
    endtask

    // Leaves Result = x[r] + 0 on the ALUResult path
    task automatic read_reg(input logic [4:0] r);
        ReadData = {12'h000, r, 3'b000, 5'd2, 7'h13}; IRWrite = 1'b1; tick();
        IRWrite = 1'b0; tick();
        ImmSrc = 3'd0; ALUSrcA = 2'd2; ALUSrcB = 2'd1; ALUControl = 4'd0; ResultSrc = 3'd2;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] alu_exp [11];
        logic [31:0] imm_exp [6];
        int cnt;
        int done_seen;

        alu_exp = '{32'h0000_0006, 32'hFFFF_FFF8, 32'h0000_0007, 32'hFFFF_FFFF,
                    32'hFFFF_FFF8, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FF80,
                    32'h01FF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        imm_exp = '{32'hFFFF_FFFF, 32'hFFFF_FFE4, 32'hFFFF_F7E4, 32'hFFF0_0000,
                    32'hFFF0_0FFE, 32'h0000_0000};

        Reset = 1'b0; ReadData = '0; MemReady = 1'b1; IRWrite = 1'b0; PCWrite = 1'b0;
        RegWrite = 1'b0; MulStart = 1'b0; ImmSrc = '0; ByteSrc = '0; ResultSrc = '0;
        ALUSrcA = '0; ALUSrcB = '0; ALUControl = '0;

        // Reset state
        #12;
        check("rst_pc", PC, 32'h100);
        check("rst_pc16", PC16, 32'h0);
        check("rst_instr", Instr, 32'h13);
        check("rst_busy", MulBusy, 1'b0);
        check("rst_done", MulDone, 1'b0);
        check("rst_result", Result, 32'h0);
        check("rst_wd", WriteData, 32'h0);
        Reset = 1'b1;
        tick();
        check("post_rst_pc", PC, 32'h100);

        // addi x1,x0,5 then read back
        exec_addi(32'h0050_0093);
        check("addi_instr", Instr, 32'h0050_0093);
        read_reg(5'd1);
        check("x1", Result, 32'h5);
        check("x1_n16", Result16, 32'h5);
        check("x1_zero", Zero, 1'b0);

        // addi x0,x0,5 must not change x0
        exec_addi(32'h0050_0013);
        read_reg(5'd0);
        check("x0", Result, 32'h0);
        check("x0_zero", Zero, 1'b1);

        // PC + 4 under stall
        ALUSrcA = 2'd0; ALUSrcB = 2'd2; ALUControl = 4'd0; ResultSrc = 3'd2;
        PCWrite = 1'b1; MemReady = 1'b0; #1;
        check("pc4_comb", Result, 32'h104);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pc_stall", PC, 32'h100);
        end
        MemReady = 1'b1;
        tick();
        check("pc_adv1", PC, 32'h104);
        tick();
        check("pc_adv2", PC, 32'h108);
        PCWrite = 1'b0;

        // x3 = 7, x4 = -1
        exec_addi(32'h0070_0193);
        exec_addi(32'hFFF0_0213);

        // Immediate formats on Instr 0xFFF00213
        ResultSrc = 3'd3;
        for (int i = 0; i < 6; i++) begin
            ImmSrc = 3'(i); #1;
            check($sformatf("imm_%0d", i), Result, imm_exp[i]);
        end

        // ALU operations: A = x4 (-1), WriteData = x3 (7)
        ReadData = 32'h0032_02B3; IRWrite = 1'b1; tick();
        IRWrite = 1'b0; tick();
        check("wd_x3", WriteData, 32'h7);
        ALUSrcA = 2'd2; ALUSrcB = 2'd0; ResultSrc = 3'd2;
        for (int i = 0; i < 11; i++) begin
            ALUControl = 4'(i); #1;
            check($sformatf("alu_%0d", i), Result, alu_exp[i]);
        end
        ALUControl = 4'd6; #1;
        check("sltu_zero", Zero, 1'b1);
        ALUControl = 4'd0; ALUSrcA = 2'd3; #1;
        check("srca_undef", Result, 32'h7);
        ALUSrcA = 2'd2; ALUSrcB = 2'd3; #1;
        check("srcb_undef", Result, 32'hFFFF_FFFF);
        ALUSrcA = 2'd1; #1;
        check("oldpc", Result, 32'h108);
        ResultSrc = 3'd5; #1;
        check("ressrc_undef", Result, 32'h0);

        // Multiply 7 x 0xFFFFFFFF
        ReadData = 32'h0041_82B3; IRWrite = 1'b1; tick();
        IRWrite = 1'b0; tick();
        check("wd_x4", WriteData, 32'hFFFF_FFFF);
        MulStart = 1'b1; tick();
        MulStart = 1'b0;
        ResultSrc = 3'd4; #1;
        check("mul_busy", MulBusy, 1'b1);
        check("mul_prev_out", Result, 32'h0);
        cnt = 0;
        while (MulBusy === 1'b1 && cnt < 40) begin
            cnt++;
            if (cnt == 10) MulStart = 1'b1;
            tick();
            MulStart = 1'b0;
        end
        check("mul_busy_cycles", cnt, 32);
        check("mul_done", MulDone, 1'b1);
        check("mul_out", Result, 32'hFFFF_FFF9);
        MemReady = 1'b0; tick();
        check("mul_done_stall", MulDone, 1'b1);
        MemReady = 1'b1; tick();
        check("mul_done_clr", MulDone, 1'b0);
        check("mul_idle", MulBusy, 1'b0);
        check("mul_out_hold", Result, 32'hFFFF_FFF9);

        // Load extension, Data = 0x80FF7F01, A = 7
        ReadData = 32'h80FF_7F01; ALUSrcA = 2'd2;
        ImmSrc = 3'd1; ALUSrcB = 2'd1; ALUControl = 4'd2; tick();   // offset 1
        ResultSrc = 3'd1; ByteSrc = 3'd0; #1;
        check("lb_off1", Result, 32'h0000_007F);
        ByteSrc = 3'd2; #1;
        check("lw", Result, 32'h80FF_7F01);
        ALUSrcB = 2'd2; ALUControl = 4'd1; tick();                  // offset 3
        ByteSrc = 3'd4; #1;
        check("lbu_off3", Result, 32'h0000_0080);
        ByteSrc = 3'd0; #1;
        check("lb_off3", Result, 32'hFFFF_FF80);
        ALUSrcB = 2'd1; ImmSrc = 3'd1; ALUControl = 4'd1; tick();   // offset 2
        ByteSrc = 3'd1; #1;
        check("lh_off2", Result, 32'hFFFF_80FF);
        ByteSrc = 3'd5; #1;
        check("lhu_off2", Result, 32'h0000_80FF);
        ByteSrc = 3'd3; #1;
        check("bytesrc_undef", Result, 32'h0);

        // x17 exists only with 32 registers
        exec_addi(32'h0090_0893);
        read_reg(5'd17);
        check("x17_n32", Result, 32'h9);
        check("x17_n16", Result16, 32'h0);

        // Reset during a multiply
        MulStart = 1'b1; tick();
        MulStart = 1'b0;
        tick(); tick(); tick();
        check("abort_busy_pre", MulBusy, 1'b1);
        #2 Reset = 1'b0;
        #1;
        check("abort_busy", MulBusy, 1'b0);
        check("abort_done", MulDone, 1'b0);
        check("abort_pc", PC, 32'h100);
        check("abort_instr", Instr, 32'h13);
        #1 Reset = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (MulDone === 1'b1) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        read_reg(5'd1);
        check("x1_after_rst", Result, 32'h0);
        exec_addi(32'h0050_0093);
        read_reg(5'd1);
        check("x1_resume", Result, 32'h5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
